// File: rtl/mem_port_arbiter_if.sv
// Request/grant/return bundle between the fetch, load/store and loader ports and the shared RAM.
// The slave view belongs to the arbiter; the master view is the requesters plus the RAM.
interface mem_port_arbiter_if #(
    parameter int AW = 30
) ();
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          l_req;
    logic          l_we;
    logic          l_lock;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [1:0]    owner;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-port (fetch/data/loader) arbiter onto one synchronous RAM: grant and issue same cycle, read data one cycle later.
// Denied requesters stall (req held, gnt low); fetch is promoted after MAX_WAIT denials; loader may lock a burst.
module mem_port_arbiter #(
    parameter int AW       = 30,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_L    = 2'd3;
    localparam logic [3:0] MAX_W    = 4'(MAX_WAIT);

    logic          lock_q;
    logic [3:0]    wait_q;
    logic [1:0]    tag_q;

    logic [1:0]    sel;
    logic          f_gnt, d_gnt, l_gnt;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    // Reset gates the selection so every output is quiet while reset is high.
    always_comb begin
        sel = OWN_NONE;
        if (reset) begin
            sel = OWN_NONE;
        end else if (lock_q) begin
            if (bus.l_req) sel = OWN_L;
        end else if (bus.f_req && wait_q == MAX_W) begin
            sel = OWN_F;
        end else if (bus.l_req) begin
            sel = OWN_L;
        end else if (bus.d_req) begin
            sel = OWN_D;
        end else if (bus.f_req) begin
            sel = OWN_F;
        end
    end

    assign f_gnt  = (sel == OWN_F);
    assign d_gnt  = (sel == OWN_D);
    assign l_gnt  = (sel == OWN_L);
    assign mem_en = f_gnt | d_gnt | l_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        case (sel)
            OWN_F: begin
                mem_addr = bus.f_addr;
            end
            OWN_D: begin
                mem_we    = bus.d_we;
                mem_be    = bus.d_we ? bus.d_be : 4'b0000;
                mem_addr  = bus.d_addr;
                mem_wdata = bus.d_wdata;
            end
            OWN_L: begin
                mem_we    = bus.l_we;
                mem_be    = bus.l_we ? 4'b1111 : 4'b0000;
                mem_addr  = bus.l_addr;
                mem_wdata = bus.l_wdata;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
            wait_q <= 4'd0;
            tag_q  <= OWN_NONE;
        end else begin
            // An idle loader releases a held lock; nothing is granted in that cycle.
            if (l_gnt)
                lock_q <= bus.l_lock;
            else if (lock_q && !bus.l_req)
                lock_q <= 1'b0;

            if (bus.f_req && !f_gnt)
                wait_q <= (wait_q >= MAX_W) ? MAX_W : wait_q + 4'd1;
            else
                wait_q <= 4'd0;

            tag_q <= (mem_en && !mem_we) ? sel : OWN_NONE;
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.owner     = sel;

    assign bus.f_rvalid  = (tag_q == OWN_F);
    assign bus.d_rvalid  = (tag_q == OWN_D);
    assign bus.l_rvalid  = (tag_q == OWN_L);
    assign bus.f_rdata   = (tag_q == OWN_F) ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata   = (tag_q == OWN_D) ? bus.mem_rdata : 32'h0;
    assign bus.l_rdata   = (tag_q == OWN_L) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios then random traffic, checked against a priority/lock/aging model and a shadow memory.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int MW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ram_clr;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(.AW(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with byte enables; contents seeded from init_word().
    logic [31:0] ram [0:255];

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    // Reference model state
    logic [31:0] shadow [0:255];
    bit          m_lock;
    int          m_wait;
    int          m_tag;
    logic [31:0] m_tag_dat;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_owner();
        if (m_lock) return bus.l_req ? 3 : 0;
        if (bus.f_req && m_wait == MW) return 1;
        if (bus.l_req) return 3;
        if (bus.d_req) return 2;
        if (bus.f_req) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_lock = 1'b0;
        m_wait = 0;
        m_tag  = 0;
    endtask

    task automatic chk_zero(input string when);
        chk({when, " f_gnt"},    32'(bus.f_gnt),    32'h0);
        chk({when, " d_gnt"},    32'(bus.d_gnt),    32'h0);
        chk({when, " l_gnt"},    32'(bus.l_gnt),    32'h0);
        chk({when, " f_rvalid"}, 32'(bus.f_rvalid), 32'h0);
        chk({when, " d_rvalid"}, 32'(bus.d_rvalid), 32'h0);
        chk({when, " l_rvalid"}, 32'(bus.l_rvalid), 32'h0);
        chk({when, " f_rdata"},  bus.f_rdata,       32'h0);
        chk({when, " d_rdata"},  bus.d_rdata,       32'h0);
        chk({when, " l_rdata"},  bus.l_rdata,       32'h0);
        chk({when, " mem_en"},   32'(bus.mem_en),   32'h0);
        chk({when, " mem_we"},   32'(bus.mem_we),   32'h0);
        chk({when, " mem_be"},   32'(bus.mem_be),   32'h0);
        chk({when, " mem_addr"}, 32'(bus.mem_addr), 32'h0);
        chk({when, " mem_wdata"}, bus.mem_wdata,    32'h0);
        chk({when, " owner"},    32'(bus.owner),    32'h0);
    endtask

    // One clock cycle: compare against the model, clock, then advance the model.
    task automatic step();
        int          g;
        logic        we;
        logic [3:0]  be;
        logic [AW-1:0] a;
        logic [31:0] wd;
        logic        freq, lreq, llock;
        #1;
        g  = exp_owner();
        we = 1'b0; be = 4'h0; a = '0; wd = 32'h0;
        case (g)
            1: a = bus.f_addr;
            2: begin we = bus.d_we; be = bus.d_we ? bus.d_be : 4'h0; a = bus.d_addr; wd = bus.d_wdata; end
            3: begin we = bus.l_we; be = bus.l_we ? 4'hF : 4'h0; a = bus.l_addr; wd = bus.l_wdata; end
            default: ;
        endcase
        chk("owner",    32'(bus.owner),  32'(g));
        chk("f_gnt",    32'(bus.f_gnt),  32'(g == 1));
        chk("d_gnt",    32'(bus.d_gnt),  32'(g == 2));
        chk("l_gnt",    32'(bus.l_gnt),  32'(g == 3));
        chk("mem_en",   32'(bus.mem_en), 32'(g != 0));
        chk("mem_we",   32'(bus.mem_we), 32'(we));
        chk("mem_be",   32'(bus.mem_be), 32'(be));
        if (g != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(a));
        if (we)     chk("mem_wdata", bus.mem_wdata, wd);
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(m_tag == 1));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_tag == 2));
        chk("l_rvalid", 32'(bus.l_rvalid), 32'(m_tag == 3));
        chk("f_rdata",  bus.f_rdata, (m_tag == 1) ? m_tag_dat : 32'h0);
        chk("d_rdata",  bus.d_rdata, (m_tag == 2) ? m_tag_dat : 32'h0);
        chk("l_rdata",  bus.l_rdata, (m_tag == 3) ? m_tag_dat : 32'h0);
        freq  = bus.f_req;
        lreq  = bus.l_req;
        llock = bus.l_lock;
        @(posedge clk);
        #1;
        if (g != 0 && !we) begin
            m_tag     = g;
            m_tag_dat = shadow[a];
        end else begin
            m_tag = 0;
        end
        for (int b = 0; b < 4; b++)
            if (we && be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
        if (g == 3)            m_lock = llock;
        else if (m_lock && !lreq) m_lock = 1'b0;
        if (freq && g != 1) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else                m_wait = 0;
        if (g == 1) bus.f_req = 1'b0;
        if (g == 2) bus.d_req = 1'b0;
        if (g == 3) bus.l_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.f_req = 0; bus.f_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 4'h0; bus.d_addr = '0; bus.d_wdata = 32'h0;
        bus.l_req = 0; bus.l_we = 0; bus.l_lock = 0; bus.l_addr = '0; bus.l_wdata = 32'h0;
        ram_clr = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        model_reset();
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset   = 1'b0;
        ram_clr = 1'b0;

        // Loader writes RAM[5], then F reads it alone.
        bus.l_req = 1; bus.l_we = 1; bus.l_lock = 0; bus.l_addr = 8'd5; bus.l_wdata = 32'hDEADBEEF;
        step();
        bus.f_req = 1; bus.f_addr = 8'd5;
        step();
        chk("f_read_data", bus.f_rdata, 32'hDEADBEEF);
        step();

        // Reset one cycle after an F read is issued: its rvalid must never appear.
        bus.f_req = 1; bus.f_addr = 8'd8;
        #1 chk("mid_read f_gnt", 32'(bus.f_gnt), 32'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk_zero("mid_reset");
        @(negedge clk);
        chk_zero("mid_reset_hold");
        reset = 1'b0;
        bus.f_req = 0;
        model_reset();
        step();

        // F and D together: D write with partial enables first, F one cycle later.
        bus.f_req = 1; bus.f_addr = 8'd9;
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 8'd9; bus.d_wdata = 32'hCAFE1234;
        step();
        step();
        step();

        // D hammering with F pending: F must win once its wait reaches MAX_WAIT.
        bus.f_req = 1; bus.f_addr = 8'd3;
        for (int i = 0; i < 5; i++) begin
            if (!bus.d_req) begin
                bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'(32 + i);
            end
            step();
        end
        step();
        step();

        // Locked loader burst while D and F wait.
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'hF; bus.d_addr = 8'd40; bus.d_wdata = $urandom;
        for (int i = 0; i < 4; i++) begin
            bus.l_req = 1; bus.l_we = 1; bus.l_lock = (i < 3); bus.l_addr = 8'(16 + i); bus.l_wdata = $urandom;
            if (i == 1) begin bus.f_req = 1; bus.f_addr = 8'd16; end
            step();
        end
        step();
        step();
        step();

        // Lock abandoned by an idle loader.
        bus.l_req = 1; bus.l_we = 0; bus.l_lock = 1; bus.l_addr = 8'd17;
        step();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'd18;
        step();
        step();
        step();

        // Random traffic over a small address window to force reuse and collisions.
        for (int n = 0; n < 400; n++) begin
            if (!bus.f_req && $urandom_range(0, 99) < 50) begin
                bus.f_req = 1; bus.f_addr = 8'($urandom_range(0, 15));
            end
            if (!bus.d_req && $urandom_range(0, 99) < 40) begin
                bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_be = 4'($urandom);
                bus.d_addr = 8'($urandom_range(0, 15)); bus.d_wdata = $urandom;
            end
            if (!bus.l_req && $urandom_range(0, 99) < 20) begin
                bus.l_req = 1; bus.l_we = 1'($urandom_range(0, 1)); bus.l_lock = ($urandom_range(0, 3) == 0);
                bus.l_addr = 8'($urandom_range(0, 15)); bus.l_wdata = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
